// File: rtl/uart_tx_io.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_io
// Purpose  : Memory-mapped UART transmitter with byte FIFO and status register.
//            Defining UART_TX_PARITY_EN switches the frame format to 8E1.
// Revision : 1.0
// ============================================================================
module uart_tx_io #(
  parameter int BAUD_DIV   = 200,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        txcs,
  input  logic        txwrite,
  input  logic        txread,
  input  logic [1:0]  txaddr,
  input  logic [7:0]  txwdata,
  output logic [15:0] txrdata,
  output logic        tx,
  output logic        busy
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0]    BIT_LAST = TW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state, state_n;
  logic [TW-1:0]      timer, timer_n;
  logic [2:0]         idx, idx_n, idx_inc;
  logic [7:0]         shift, shift_n;
  logic               tx_n;
  logic               pop;
  logic               bit_end;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [FIFO_AW:0]   count;
  logic               full, empty, ready, overflow;
  logic               wr_hit, push, drop, status_rd, shifting;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign wr_hit    = txcs & txwrite & (txaddr == 2'd0);
  assign push      = wr_hit & ~full;
  assign drop      = wr_hit & full;
  assign status_rd = txcs & txread & (txaddr == 2'd2);
  assign shifting  = (state != IDLE);
  assign bit_end   = (timer == BIT_LAST);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= txwdata;
  end

  // ready lags count by one edge, giving the two-edge write-to-start latency
  always_ff @(posedge clock) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b0;
      overflow <= 1'b0;
      txrdata  <= '0;
      busy     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ready <= ~empty;
      if (drop)           overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
      if (txcs & txread)
        txrdata <= (txaddr == 2'd2) ? {12'b0, overflow, shifting, full, empty} : 16'h0000;
      busy <= shifting | ~empty;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    idx_inc = idx + 3'd1;
    case (state)
      IDLE: begin
        tx_n    = 1'b1;
        timer_n = '0;
        if (ready & ~empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_n = '0;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = ^shift;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = idx_inc;
            tx_n  = shift[idx_inc];
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          timer_n = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          timer_n = '0;
          if (ready & ~empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_io
// Purpose  : Directed self-checking bench for uart_tx_io with BAUD_DIV=4.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_io;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic        clock = 1'b0;
  logic        rst;
  logic        txcs;
  logic        txwrite;
  logic        txread;
  logic [1:0]  txaddr;
  logic [7:0]  txwdata;
  logic [15:0] txrdata;
  logic        tx;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_io #(
    .BAUD_DIV   (BD),
    .FIFO_DEPTH (8),
    .FIFO_AW    (3)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .txcs    (txcs),
    .txwrite (txwrite),
    .txread  (txread),
    .txaddr  (txaddr),
    .txwdata (txwdata),
    .txrdata (txrdata),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input logic cs);
    txcs    = cs;
    txwrite = 1'b1;
    txaddr  = a;
    txwdata = d;
    tick();
    txcs    = 1'b0;
    txwrite = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, input logic cs);
    txcs   = cs;
    txread = 1'b1;
    txaddr = a;
    tick();
    txcs   = 1'b0;
    txread = 1'b0;
  endtask

  // Called just after the edge that drives the start bit; returns one edge
  // after the stop bit's final cycle.
  task automatic expect_frame(input logic [7:0] d);
    logic exp;
    for (int c = 0; c < NBITS * BD; c++) begin
      int b;
      b = c / BD;
      if (b == 0)                  exp = 1'b0;
      else if (b <= 8)             exp = d[b-1];
      else if (NBITS == 11 && b == 9) exp = ^d;
      else                         exp = 1'b1;
      check($sformatf("frame_%h_c%0d", d, c), {15'b0, tx}, {15'b0, exp});
      tick();
    end
  endtask

  initial begin
    logic seen_low;
    rst = 1'b1; txcs = 1'b0; txwrite = 1'b0; txread = 1'b0;
    txaddr = 2'd0; txwdata = 8'h00;
    tick();
    tick();
    check("rst_tx", {15'b0, tx}, 16'h0001);
    check("rst_busy", {15'b0, busy}, 16'h0000);
    check("rst_rdata", txrdata, 16'h0000);
    rst = 1'b0;

    // Single byte: start bit on the second edge after the write edge
    do_write(2'd0, 8'hA5, 1'b1);
    check("lat_e0_tx", {15'b0, tx}, 16'h0001);
    tick();
    check("lat_e1_tx", {15'b0, tx}, 16'h0001);
    check("lat_e1_busy", {15'b0, busy}, 16'h0001);
    tick();
    expect_frame(8'hA5);
    check("a5_end_tx", {15'b0, tx}, 16'h0001);
    check("a5_end_busy", {15'b0, busy}, 16'h0001);
    tick();
    check("a5_idle_busy", {15'b0, busy}, 16'h0000);

    // Back-to-back frames with no idle gap, order preserved
    do_write(2'd0, 8'h01, 1'b1);
    do_write(2'd0, 8'h80, 1'b1);
    tick();
    expect_frame(8'h01);
    expect_frame(8'h80);
    check("b2b_end_tx", {15'b0, tx}, 16'h0001);
    tick();
    check("b2b_idle_busy", {15'b0, busy}, 16'h0000);

    // Overflow: one byte on the line, 8 queued, 9th dropped
    do_write(2'd0, 8'h3C, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 9; i++) do_write(2'd0, 8'(i + 16), 1'b1);
    do_read(2'd2, 1'b1);
    check("ovf_status1", txrdata, 16'h000E);
    do_read(2'd2, 1'b1);
    check("ovf_status2", txrdata, 16'h0006);
    check("ovf_busy", {15'b0, busy}, 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_rst_busy", {15'b0, busy}, 16'h0000);

    // Reset during data bit 3 of 0xFF with three bytes queued
    do_write(2'd0, 8'hFF, 1'b1);
    do_write(2'd0, 8'h11, 1'b1);
    do_write(2'd0, 8'h22, 1'b1);
    do_write(2'd0, 8'h33, 1'b1);
    for (int i = 0; i < 16; i++) tick();
    check("mid_bit3_tx", {15'b0, tx}, 16'h0001);
    check("mid_bit3_busy", {15'b0, busy}, 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_tx", {15'b0, tx}, 16'h0001);
    check("abort_busy", {15'b0, busy}, 16'h0000);
    do_read(2'd2, 1'b1);
    check("abort_status", txrdata, 16'h0001);
    seen_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      seen_low = seen_low | ~tx;
    end
    check("abort_no_frames", {15'b0, seen_low}, 16'h0000);
    check("abort_busy_late", {15'b0, busy}, 16'h0000);

    // Writes to a non-data address or without chip select are ignored
    do_write(2'd1, 8'h55, 1'b1);
    do_write(2'd0, 8'h66, 1'b0);
    seen_low = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen_low = seen_low | ~tx;
    end
    check("ign_tx", {15'b0, seen_low}, 16'h0000);
    check("ign_busy", {15'b0, busy}, 16'h0000);
    do_read(2'd2, 1'b1);
    check("ign_status", txrdata, 16'h0001);
    do_read(2'd0, 1'b0);
    check("read_nocs_hold", txrdata, 16'h0001);
    do_read(2'd0, 1'b1);
    check("read_addr0", txrdata, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
